// File: rtl/prio_arb_pkg.sv
// prio_arb_pkg
// Shared definitions for the priority arbiter slice: the arbiter FSM state
// encoding and the default number of request lines.
// No ports (package).

package prio_arb_pkg;

  // Arbiter FSM: IDLE waits for requests, GRANT holds a live grant.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Default number of request lines.
  localparam int DEFAULT_N = 8;

endpackage : prio_arb_pkg

// File: rtl/prio_enc_n.sv
// prio_enc_n
// Combinational N-to-W priority encoder: reports the highest set bit of its
// input vector and whether any bit is set at all.
// Ports:
//   in_vec    input  [N-1:0]  vector to encode
//   enc_idx   output [W-1:0]  index of the highest set bit (0 when none set)
//   enc_valid output          at least one bit of in_vec is set

module prio_enc_n #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] in_vec,
  output logic [W-1:0] enc_idx,
  output logic         enc_valid
);

  // Ascending scan so that the last (highest) set bit overwrites lower ones.
  always_comb begin
    enc_idx   = '0;
    enc_valid = |in_vec;
    for (int i = 0; i < N; i++) begin
      if (in_vec[i]) begin
        enc_idx = W'(i);
      end
    end
  end

endmodule : prio_enc_n

// File: rtl/prio_arbiter_n.sv
// prio_arbiter_n
// N-way request arbiter with a two-state (IDLE/GRANT) FSM. A grant is chosen
// from the request vector sampled in IDLE and held until the consumer
// acknowledges it or the granted requester withdraws.
// Configuration macro: PRIO_ARBITER_ROUND_ROBIN_EN
//   undefined -> fixed priority, highest set index wins, no pointer register
//   defined   -> round-robin, last acknowledged index gets lowest priority
// Ports:
//   clk          input          rising-edge clock
//   rst_n        input          synchronous active-low reset
//   req          input  [N-1:0] request vector, bit i = requester i
//   ack          input          consumer has taken the current grant
//   grant_valid  output         grant_idx/grant_onehot hold a live grant
//   grant_idx    output [W-1:0] binary index of the granted requester
//   grant_onehot output [N-1:0] one-hot grant, all-zero when no live grant
//   zero         output         req sampled at the previous edge was all-zero

module prio_arbiter_n
  import prio_arb_pkg::*;
#(
  parameter int N = DEFAULT_N,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         ack,
  output logic         grant_valid,
  output logic [W-1:0] grant_idx,
  output logic [N-1:0] grant_onehot,
  output logic         zero
);

  arb_state_e   state_q, state_d;
  logic         grant_valid_q, grant_valid_d;
  logic [W-1:0] grant_idx_q, grant_idx_d;
  logic [N-1:0] grant_onehot_q, grant_onehot_d;
  logic         zero_q, zero_d;
  // Low for the first edge after reset release so no grant is issued on it.
  logic         armed_q, armed_d;

  logic [N-1:0] enc_in;
  logic [W-1:0] enc_idx;
  logic         enc_valid;
  logic [W-1:0] win_idx;

  prio_enc_n #(
    .N(N),
    .W(W)
  ) u_enc (
    .in_vec    (enc_in),
    .enc_idx   (enc_idx),
    .enc_valid (enc_valid)
  );

`ifdef PRIO_ARBITER_ROUND_ROBIN_EN
  logic [W-1:0] ptr_q, ptr_d;
  logic [W:0]   unrot_sum;

  // Rotate req right by the pointer: rotated bit N-1 is original bit
  // (ptr-1) mod N, so the encoder's descending search starts there and the
  // pointed-to requester itself lands on bit 0 (lowest priority).
  always_comb begin
    enc_in = '0;
    for (int j = 0; j < N; j++) begin
      enc_in[j] = req[(j + int'(ptr_q)) % N];
    end
  end

  // Undo the rotation: original index = (encoded + ptr) mod N.
  always_comb begin
    unrot_sum = {1'b0, enc_idx} + {1'b0, ptr_q};
    if (unrot_sum >= (W+1)'(N)) begin
      unrot_sum = unrot_sum - (W+1)'(N);
    end
    win_idx = unrot_sum[W-1:0];
  end
`else
  assign enc_in  = req;
  assign win_idx = enc_idx;
`endif

  // Next-state logic. The zero flag tracks req every cycle regardless of
  // state; grant fields are only loaded from IDLE so later requests wait.
  always_comb begin
    state_d        = state_q;
    grant_valid_d  = grant_valid_q;
    grant_idx_d    = grant_idx_q;
    grant_onehot_d = grant_onehot_q;
    zero_d         = (req == '0);
    armed_d        = 1'b1;
`ifdef PRIO_ARBITER_ROUND_ROBIN_EN
    ptr_d          = ptr_q;
`endif
    unique case (state_q)
      IDLE: begin
        grant_valid_d  = 1'b0;
        grant_onehot_d = '0;
        if (armed_q && enc_valid) begin
          state_d        = GRANT;
          grant_valid_d  = 1'b1;
          grant_idx_d    = win_idx;
          grant_onehot_d = N'(1) << win_idx;
        end
      end
      GRANT: begin
        // Ack takes precedence over a simultaneous withdrawal.
        if (ack) begin
          state_d        = IDLE;
          grant_valid_d  = 1'b0;
          grant_onehot_d = '0;
`ifdef PRIO_ARBITER_ROUND_ROBIN_EN
          ptr_d          = grant_idx_q;
`endif
        end else if (!req[grant_idx_q]) begin
          state_d        = IDLE;
          grant_valid_d  = 1'b0;
          grant_onehot_d = '0;
        end
      end
      default: begin
        state_d        = IDLE;
        grant_valid_d  = 1'b0;
        grant_onehot_d = '0;
      end
    endcase
  end

  // State and registered outputs; reset wins over everything, mid-grant too.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      grant_valid_q  <= 1'b0;
      grant_idx_q    <= '0;
      grant_onehot_q <= '0;
      zero_q         <= 1'b1;
      armed_q        <= 1'b0;
`ifdef PRIO_ARBITER_ROUND_ROBIN_EN
      ptr_q          <= '0;
`endif
    end else begin
      state_q        <= state_d;
      grant_valid_q  <= grant_valid_d;
      grant_idx_q    <= grant_idx_d;
      grant_onehot_q <= grant_onehot_d;
      zero_q         <= zero_d;
      armed_q        <= armed_d;
`ifdef PRIO_ARBITER_ROUND_ROBIN_EN
      ptr_q          <= ptr_d;
`endif
    end
  end

  assign grant_valid  = grant_valid_q;
  assign grant_idx    = grant_idx_q;
  assign grant_onehot = grant_onehot_q;
  assign zero         = zero_q;

endmodule : prio_arbiter_n
